// File: rtl/booth_product_accumulator.sv
// Sums sequences of signed Booth-multiplier products into a wider accumulator.
// Each finished sequence is held on a valid/ready port with a beat count and a sticky overflow flag.
module booth_product_accumulator #(
  parameter int PROD_W   = 16,
  parameter int ACC_W    = 24,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PROD_W-1:0] p_in,
  input  logic              p_valid,
  input  logic              p_last,
  output logic              p_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [7:0]        count,
  output logic              overflow,
  output logic [1:0]        state_dbg_o
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a producer holding valid keeps
  // its data stable until the transfer.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic [ACC_W-1:0]   p_sext;
  logic [ACC_W:0]     sum_ext;
  logic               add_ovf;
  logic [ACC_W-1:0]   add_res;
  logic [7:0]         count_inc;

  assign p_ready = (state_q != HOLD) & ~reset;
  assign accept  = p_valid & p_ready;

  assign p_sext  = {{(ACC_W-PROD_W){p_in[PROD_W-1]}}, p_in};
  // One guard bit: the sum is exact, and overflow shows as the top two bits differing.
  assign sum_ext = {acc_q[ACC_W-1], acc_q} + {p_sext[ACC_W-1], p_sext};
  assign add_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

  always_comb begin
    add_res = sum_ext[ACC_W-1:0];
    if (SATURATE && add_ovf) begin
      add_res = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = p_sext;
          count_d = 8'd1;
          ovf_d   = 1'b0;
          state_d = p_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = add_res;
          count_d = count_inc;
          ovf_d   = ovf_q | add_ovf;
          state_d = p_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (acc_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_out     = acc_q;
  assign acc_valid   = (state_q == HOLD);
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench for booth_product_accumulator: a saturating and a wrapping
// instance share stimulus; finished results are scored against an expected queue.
module tb_booth_product_accumulator;

  logic        clock;
  logic        reset;
  logic [15:0] p_in;
  logic        p_valid;
  logic        p_last;
  logic        acc_ready;

  logic        p_ready,   w_p_ready;
  logic [23:0] acc_out,   w_acc_out;
  logic        acc_valid, w_acc_valid;
  logic [7:0]  count,     w_count;
  logic        overflow,  w_overflow;
  logic [1:0]  state_dbg, w_state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];

  booth_product_accumulator #(.PROD_W(16), .ACC_W(24), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .p_in(p_in), .p_valid(p_valid), .p_last(p_last),
    .p_ready(p_ready), .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .count(count), .overflow(overflow), .state_dbg_o(state_dbg)
  );

  booth_product_accumulator #(.PROD_W(16), .ACC_W(24), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset(reset), .p_in(p_in), .p_valid(p_valid), .p_last(p_last),
    .p_ready(w_p_ready), .acc_out(w_acc_out), .acc_valid(w_acc_valid), .acc_ready(acc_ready),
    .count(w_count), .overflow(w_overflow), .state_dbg_o(w_state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on falling edges.
  task automatic align();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] v, input logic last);
    logic rdy;
    logic done;
    done    = 1'b0;
    p_in    = v;
    p_last  = last;
    p_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      rdy = p_ready;
      align();
      done = rdy;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // scoreboard: every result handshake pops the oldest expected result
  always @(negedge clock) begin
    if (!reset && acc_valid && acc_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {8'd0, acc_out}, 32'hFFFFFFFF);
      end else begin
        check("result", {8'd0, acc_out}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b1; p_in = '0; p_valid = 1'b0; p_last = 1'b0; acc_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_p_ready", p_ready, 0);
    check("rst_acc_valid", acc_valid, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", state_dbg, 0);
    align();
    reset = 1'b0;

    // three-beat sequence, consumer always ready
    exp_q.push_back(24'd75);
    send(16'd100, 1'b0);
    send(-16'sd50, 1'b0);
    send(16'd25, 1'b1);
    p_valid = 1'b0; p_last = 1'b0;
    @(negedge clock);
    check("t1_valid", acc_valid, 1);
    check("t1_count", count, 3);
    check("t1_ovf", overflow, 0);
    align();
    @(negedge clock);
    check("t1_valid_drop", acc_valid, 0);
    check("t1_held_out", acc_out, 75);
    align();

    // single most-negative product
    exp_q.push_back(24'hFF8000);
    send(16'h8000, 1'b1);
    p_valid = 1'b0; p_last = 1'b0;
    @(negedge clock);
    check("t2_valid", acc_valid, 1);
    check("t2_acc", acc_out, 32'h00FF8000);
    check("t2_count", count, 1);
    align();
    @(negedge clock);
    check("t2_valid_1cyc", acc_valid, 0);
    align();

    // 257 x 32767: 256 beats still fit, the 257th overflows
    for (int i = 0; i < 256; i++) send(16'd32767, 1'b0);
    p_valid = 1'b0;
    @(negedge clock);
    check("t3_256_acc", acc_out, 32'h007FFF00);
    check("t3_256_ovf", overflow, 0);
    check("t3_256_count", count, 255);
    align();
    exp_q.push_back(24'h7FFFFF);
    send(16'd32767, 1'b1);
    p_valid = 1'b0; p_last = 1'b0;
    @(negedge clock);
    check("t3_sat_acc", acc_out, 32'h007FFFFF);
    check("t3_sat_ovf", overflow, 1);
    check("t3_sat_count", count, 255);
    check("t3_wrap_acc", w_acc_out, (257 * 32767) % (1 << 24));
    check("t3_wrap_ovf", w_overflow, 1);
    check("t3_wrap_count", w_count, 255);
    align();

    // back-pressure in HOLD with a waiting beat
    acc_ready = 1'b0;
    exp_q.push_back(24'd11);
    send(16'd5, 1'b0);
    send(16'd6, 1'b1);
    p_in = 16'd9; p_last = 1'b1; p_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t4_hold_valid", acc_valid, 1);
      check("t4_hold_ready", p_ready, 0);
      check("t4_hold_acc", acc_out, 11);
    end
    align();
    exp_q.push_back(24'd9);
    acc_ready = 1'b1;
    align();
    @(negedge clock);
    check("t4_valid_drop", acc_valid, 0);
    check("t4_idle_ready", p_ready, 1);
    check("t4_idle_acc", acc_out, 11);
    check("t4_idle_count", count, 2);
    align();
    p_valid = 1'b0; p_last = 1'b0;
    @(negedge clock);
    check("t4_new_valid", acc_valid, 1);
    check("t4_new_acc", acc_out, 9);
    check("t4_new_count", count, 1);
    align();

    // reset in the middle of a sequence
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    p_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_ready", p_ready, 0);
    align();
    reset = 1'b0;
    @(negedge clock);
    check("t5_acc", acc_out, 0);
    check("t5_count", count, 0);
    check("t5_ovf", overflow, 0);
    check("t5_valid", acc_valid, 0);
    check("t5_state", state_dbg, 0);
    align();
    exp_q.push_back(24'd7);
    send(16'd3, 1'b0);
    send(16'd4, 1'b1);
    p_valid = 1'b0; p_last = 1'b0;
    @(negedge clock);
    check("t5_new_valid", acc_valid, 1);
    check("t5_new_count", count, 2);
    align();

    // bubbles carrying a stray p_last
    exp_q.push_back(24'd30);
    send(16'd10, 1'b0);
    p_valid = 1'b0; p_in = 16'h7777; p_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("t6_bub_acc", acc_out, 10);
      check("t6_bub_count", count, 1);
      check("t6_bub_valid", acc_valid, 0);
      align();
    end
    send(16'd20, 1'b1);
    p_valid = 1'b0; p_last = 1'b0;
    @(negedge clock);
    check("t6_valid", acc_valid, 1);
    check("t6_count", count, 2);
    align();

    repeat (2) align();
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
